xz_scan_buffer: RTL and testbench

Downstream capture stage for four-state multi-driven output nets. Each cycle it samples a flattened 4-state vector, such as a 5×2 tri0 array flattened to 10 bits. It resolves X and Z bits to 2-state data, records per-bit X and Z masks, and queues the results in a small FIFO drained through a valid/ready port. Running statistics expose how often unresolved values reach the boundary.

---
 rtl/xz_scan_pkg.sv | 16 +
 rtl/xz_classify.sv | 22 ++
 rtl/xz_scan_buffer.sv | 62 ++++++
 tb/tb_xz_scan_buffer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/xz_scan_pkg.sv
// xz_scan_pkg: shared defaults, entry/classification types and the per-bit 4-state classifier
package xz_scan_pkg;
  localparam int W_DEF = 10;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;
  typedef struct packed {
    logic [W_DEF-1:0] data;
    logic [W_DEF-1:0] xmask;
    logic [W_DEF-1:0] zmask;
  } xz_entry_t;
  typedef enum logic [1:0] {B0, B1, BX, BZ} xz_cls_e;
  // Only an unknown bit can be X or Z; the case-equality test then tells them apart.
  function automatic xz_cls_e classify_bit(input logic b);
    return $isunknown(b) ? ((b === 1'bx) ? BX : BZ) : (b ? B1 : B0);
  endfunction
endpackage

// File: rtl/xz_classify.sv
// xz_classify: combinational W-bit 4-state resolver; XZ_SCAN_ZPULL_EN makes Z resolve to 1 (tri1)
module xz_classify import xz_scan_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] raw,
  output logic [W-1:0] data,
  output logic [W-1:0] xmask,
  output logic [W-1:0] zmask
);
`ifdef XZ_SCAN_ZPULL_EN
  localparam logic ZPULL = 1'b1;
`else
  localparam logic ZPULL = 1'b0;
`endif
  for (genvar i = 0; i < W; i++) begin : g_bit
    xz_cls_e c;
    assign c = classify_bit(raw[i]);
    assign data[i] = (c == B1) || ((c == BZ) && ZPULL);
    assign xmask[i] = c == BX;
    assign zmask[i] = c == BZ;
  end
endmodule

// File: rtl/xz_scan_buffer.sv
// xz_scan_buffer: resolves sampled 4-state vectors into a valid/ready FIFO with X/Z statistics
// Z pull-up resolution is selected by XZ_SCAN_ZPULL_EN inside xz_classify.
module xz_scan_buffer import xz_scan_pkg::*; #(
  parameter int W = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [W-1:0]     out_xmask,
  output logic [W-1:0]     out_zmask,
  output logic [CNT_W-1:0] xz_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             drop_sticky
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] cd, cx, cz;
  logic [W-1:0] dmem [DEPTH];
  logic [W-1:0] xmem [DEPTH];
  logic [W-1:0] zmem [DEPTH];
  logic [AW:0] wp, rp;
  logic full, empty, push, pop, drop;
  xz_classify #(.W(W)) u_cls (.raw(in_data), .data(cd), .xmask(cx), .zmask(cz));
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    pop = !empty && out_ready;
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
    out_valid = !empty;
    out_data = empty ? '0 : dmem[rp[AW-1:0]];
    out_xmask = empty ? '0 : xmem[rp[AW-1:0]];
    out_zmask = empty ? '0 : zmem[rp[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (push) begin
      dmem[wp[AW-1:0]] <= cd;
      xmem[wp[AW-1:0]] <= cx;
      zmem[wp[AW-1:0]] <= cz;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      xz_count <= '0;
      drop_count <= '0;
      drop_sticky <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && |(cx | cz) && !(&xz_count)) xz_count <= xz_count + 1'b1;
      if (drop && !(&drop_count)) drop_count <= drop_count + 1'b1;
      if (drop) drop_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_xz_scan_buffer.sv
// tb_xz_scan_buffer: directed checks of resolution, FIFO ordering, drops, saturation and reset
module tb_xz_scan_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [9:0] out_data, out_xmask, out_zmask;
  logic [15:0] xz_count, drop_count;
  logic drop_sticky;
  logic zen = 1'b0;
  wire zbit;
  int checks = 0;
  int errors = 0;
  logic four_state;
  logic [9:0] xz_vec;
  logic [9:0] exp_d, exp_x, exp_z;
  assign zbit = zen ? 1'b1 : 1'bz;
  always #5 clk = ~clk;
  xz_scan_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_xmask(out_xmask), .out_zmask(out_zmask), .xz_count(xz_count),
    .drop_count(drop_count), .drop_sticky(drop_sticky)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #1;
    // A two-state simulator cannot carry X/Z; expectations then follow the values it really applied.
    four_state = $isunknown(zbit);
    step;
    step;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_xmask", 32'(out_xmask), 0);
    chk("rst_zmask", 32'(out_zmask), 0);
    chk("rst_xz", 32'(xz_count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_sticky", 32'(drop_sticky), 0);
    rst_n = 1'b1;
    step;
    in_valid = 1'b1;
    in_data = 10'b0101010101;
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32'h155);
    chk("t1_xmask", 32'(out_xmask), 0);
    chk("t1_zmask", 32'(out_zmask), 0);
    chk("t1_xz", 32'(xz_count), 0);
    in_valid = 1'b1;
    in_data = {1'b1, 1'bx, 1'b0, zbit, 6'b0};
    #1;
    xz_vec = in_data;
`ifdef XZ_SCAN_ZPULL_EN
    exp_d = four_state ? 10'h240 : xz_vec;
`else
    exp_d = four_state ? 10'h200 : xz_vec;
`endif
    exp_x = four_state ? 10'h100 : 10'h000;
    exp_z = four_state ? 10'h040 : 10'h000;
    step;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_data", 32'(out_data), 32'(exp_d));
    chk("t2_xmask", 32'(out_xmask), 32'(exp_x));
    chk("t2_zmask", 32'(out_zmask), 32'(exp_z));
    chk("t2_xz", 32'(xz_count), four_state ? 1 : 0);
    out_ready = 1'b1;
    step;
    chk("t2_empty", 32'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data = 10'(i);
      step;
    end
    in_valid = 1'b0;
    chk("full_valid", 32'(out_valid), 1);
    chk("full_head", 32'(out_data), 1);
    chk("full_drop", 32'(drop_count), 2);
    chk("full_sticky", 32'(drop_sticky), 1);
    in_valid = 1'b1;
    in_data = 10'd7;
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    chk("pp_drop", 32'(drop_count), 2);
    chk("pp_head0", 32'(out_data), 2);
    step;
    chk("pp_head1", 32'(out_data), 3);
    step;
    chk("pp_head2", 32'(out_data), 4);
    step;
    chk("pp_head3", 32'(out_data), 7);
    chk("pp_valid3", 32'(out_valid), 1);
    step;
    chk("pp_empty", 32'(out_valid), 0);
    if (four_state) begin
      in_valid = 1'b1;
      in_data = 10'b00_0000_001x;
      repeat (16'hFFFD) step;
      in_valid = 1'b0;
    end
    chk("sat_pre", 32'(xz_count), four_state ? 32'hFFFE : 0);
    in_valid = 1'b1;
    in_data = 10'b00_0000_001x;
    step;
    step;
    in_valid = 1'b0;
    chk("sat_hold", 32'(xz_count), four_state ? 32'hFFFF : 0);
    step;
    step;
    chk("sat_drained", 32'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data = 10'(i * 17);
      step;
    end
    in_valid = 1'b0;
    chk("mid_valid", 32'(out_valid), 1);
    chk("mid_head", 32'(out_data), 32'h011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_data", 32'(out_data), 0);
    chk("ar_xz", 32'(xz_count), 0);
    chk("ar_drop", 32'(drop_count), 0);
    chk("ar_sticky", 32'(drop_sticky), 0);
    step;
    rst_n = 1'b1;
    step;
    chk("post_rst_empty", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_data = 10'h3AA;
    step;
    in_valid = 1'b0;
    chk("post_valid", 32'(out_valid), 1);
    chk("post_data", 32'(out_data), 32'h3AA);
    out_ready = 1'b1;
    step;
    chk("post_alone", 32'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
